// File: rtl/fp8_pkg.sv
// Shared definitions for the FP8 (e4m3) multiply path.
// Holds the e4m3 field constants used by the multiplier and the state
// encoding of the scheduler that shares one multiplier between requesters.
package fp8_pkg;

    localparam int          E4M3_W       = 8;
    localparam int          E4M3_BIAS    = 7;
    localparam logic [7:0]  E4M3_ZERO    = 8'h00;
    // Largest finite magnitude (448); e4m3 has no infinity, S.1111.111 is NaN.
    localparam logic [6:0]  E4M3_MAXMAG  = 7'h7E;
    localparam logic [6:0]  E4M3_NANMAG  = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP
    } sched_state_t;

endpackage

// File: rtl/float_mul_sched_if.sv
// Request/response bundle between the FP8 compute clients and the
// multiplier scheduler.
//   req_valid/req_ready : per-requester operand handshake (ready is one-hot)
//   req_a/req_b         : packed e4m3 operands, slot i = bits [8i+7:8i]
//   resp_*              : single response channel carrying product, id, timeout flag
//   busy                : scheduler is working on an operation
// master = client side, slave = scheduler side.
interface float_mul_sched_if #(
    parameter int N = 4
);
    import fp8_pkg::*;

    localparam int ID_W = $clog2(N);

    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [E4M3_W*N-1:0]   req_a;
    logic [E4M3_W*N-1:0]   req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [E4M3_W-1:0]     resp_y;
    logic [ID_W-1:0]       resp_id;
    logic                  resp_err;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_y, resp_id, resp_err, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_y, resp_id, resp_err, busy
    );

endinterface

// File: rtl/float_multiplier_e4m3.sv
// Single e4m3 multiplier with an asynchronous, active-high reset.
// While reset is high the result is cleared and is_output_valid is low; the
// first rising clock after reset releases registers a*b and raises
// is_output_valid. Operands must stay stable from reset release onwards.
//   clock, reset     : clock and async reset (the scheduler pulses reset to start)
//   a, b             : e4m3 operands
//   y                : e4m3 product (round to nearest even, saturating, FTZ)
//   is_output_valid  : y holds the product of the current operands
module float_multiplier_e4m3 (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y,
    output logic       is_output_valid
);
    import fp8_pkg::*;

    logic [E4M3_W-1:0] y_d, y_q;
    logic              valid_d, valid_q;
    logic              sign;
    logic [7:0]        prod;
    logic              norm;
    logic [6:0]        prod_n;
    logic [2:0]        mant;
    logic              round_up;
    logic signed [6:0] exp_s;
    logic signed [9:0] packed_s;

    // Subnormal operands are flushed to zero. The 4x4 significand product is
    // normalised, rounded to nearest even, and the rounding carry is allowed
    // to ripple into the exponent field of the packed {exp, mant} value.
    always_comb begin
        sign     = a[7] ^ b[7];
        prod     = 8'({1'b1, a[2:0]}) * 8'({1'b1, b[2:0]});
        norm     = prod[7];
        prod_n   = norm ? prod[6:0] : {prod[5:0], 1'b0};
        mant     = prod_n[6:4];
        round_up = prod_n[3] & ((|prod_n[2:0]) | prod_n[4]);
        exp_s    = $signed({3'b000, a[6:3]}) + $signed({3'b000, b[6:3]})
                   - $signed(7'(E4M3_BIAS)) + $signed({6'b000000, norm});
        packed_s = $signed({exp_s, mant}) + $signed({9'b0, round_up});
        y_d      = {sign, E4M3_ZERO[6:0]};
        valid_d  = 1'b1;
        if (a[6:0] == E4M3_NANMAG || b[6:0] == E4M3_NANMAG) begin
            y_d = {sign, E4M3_NANMAG};
        end else if (a[6:3] == 4'd0 || b[6:3] == 4'd0 || exp_s <= 0) begin
            y_d = {sign, E4M3_ZERO[6:0]};
        end else if (packed_s > 10'sd126) begin
            y_d = {sign, E4M3_MAXMAG};
        end else begin
            y_d = {sign, packed_s[6:0]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            y_q     <= E4M3_ZERO;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign y               = y_q;
    assign is_output_valid = valid_q;

endmodule

// File: rtl/rr_pick.sv
// Combinational N-way round-robin priority selector.
//   req      : request vector
//   ptr      : index that has the highest priority this cycle
//   grant    : one-hot winner (zero when no request)
//   grant_id : index of the winner
//   any      : at least one request present
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any
);

    // Walk from the farthest slot back towards ptr so the slot closest to
    // ptr (in wrap order) is the last one written and therefore wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                grant                         = '0;
                grant[(int'(ptr) + k) % N]    = 1'b1;
                grant_id                      = ID_W'((int'(ptr) + k) % N);
                any                           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/float_mul_sched.sv
// Round-robin scheduler sharing one float_multiplier_e4m3 between N clients.
// An operand pair is accepted in IDLE, the multiplier is reset for one cycle
// (LAUNCH) with the latched operands applied, the result is awaited in WAIT
// under a MAX_WAIT-cycle timeout, and the product is offered in RESP.
//   clock, reset : sole clock, synchronous active-high reset
//   bus          : request/response bundle (slave side)
module float_mul_sched #(
    parameter int N        = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic               clock,
    input  logic               reset,
    float_mul_sched_if.slave   bus
);
    import fp8_pkg::*;

    localparam int ID_W  = $clog2(N);
    localparam int CNT_W = $clog2(MAX_WAIT) + 1;

    sched_state_t      state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [E4M3_W-1:0] a_q, a_d, b_q, b_d;
    logic [E4M3_W-1:0] resp_y_q, resp_y_d;
    logic              resp_err_q, resp_err_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic [N-1:0]      grant;
    logic [ID_W-1:0]   grant_id;
    logic              any_req;
    logic              unit_reset;
    logic              unit_valid;
    logic [E4M3_W-1:0] unit_y;

    rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
        .req      (bus.req_valid),
        .ptr      (ptr_q),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any_req)
    );

    // The unit's async reset is built only from the primary reset and the
    // registered state, so it cannot glitch from request-side logic.
    assign unit_reset = reset | (state_q == ST_LAUNCH);

    float_multiplier_e4m3 u_mul (
        .clock           (clock),
        .reset           (unit_reset),
        .a               (a_q),
        .b               (b_q),
        .y               (unit_y),
        .is_output_valid (unit_valid)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        wait_cnt_d = wait_cnt_q;
        resp_y_d   = resp_y_q;
        resp_err_d = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    a_d     = bus.req_a[int'(grant_id) * E4M3_W +: E4M3_W];
                    b_d     = bus.req_b[int'(grant_id) * E4M3_W +: E4M3_W];
                    id_d    = grant_id;
                    // Explicit wrap so a non-power-of-two N is handled.
                    ptr_d   = (int'(grant_id) == N - 1) ? '0 : grant_id + 1'b1;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                // A result arriving on the timeout cycle still wins.
                if (unit_valid) begin
                    resp_y_d   = unit_y;
                    resp_err_d = 1'b0;
                    state_d    = ST_RESP;
                end else if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    resp_y_d   = E4M3_ZERO;
                    resp_err_d = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            a_q        <= E4M3_ZERO;
            b_q        <= E4M3_ZERO;
            wait_cnt_q <= '0;
            resp_y_q   <= E4M3_ZERO;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            wait_cnt_q <= wait_cnt_d;
            resp_y_q   <= resp_y_d;
            resp_err_q <= resp_err_d;
        end
    end

    // Grants are withheld during reset so no operand can be taken then.
    assign bus.req_ready  = (state_q == ST_IDLE && !reset) ? grant : '0;
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_y     = resp_y_q;
    assign bus.resp_id    = id_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule
